// File: rtl/pps_disciplined_gen.sv
// Disciplined PPS generator: free-running phase counter that realigns to an
// external PPS reference and tracks acquire/lock/holdover status.
module pps_disciplined_gen #(
   parameter int unsigned NBITS        = 26,
   parameter int unsigned NCLKS_TOTAL  = 50000000,
   parameter int unsigned PULSE_CLKS   = 5000000,
   parameter int unsigned SYNC_WINDOW  = 500,
   parameter int unsigned LOCK_COUNT   = 3,
   parameter int unsigned HOLDOVER_MAX = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  sync_in,
   output logic [NBITS-1:0]      counter_out,
   output logic                  pps_out,
   output logic                  tick,
   output logic                  locked,
   output logic                  holdover,
   output logic signed [NBITS:0] offset
);

   localparam int unsigned HW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MW = $clog2(HOLDOVER_MAX + 1);
   localparam int unsigned OW = NBITS + 1;

   localparam logic [NBITS-1:0] CNT_LAST  = NBITS'(NCLKS_TOTAL - 1);
   localparam logic [NBITS-1:0] WIN_LO    = NBITS'(SYNC_WINDOW);
   localparam logic [NBITS-1:0] WIN_HI    = NBITS'(NCLKS_TOTAL - SYNC_WINDOW);
   localparam logic [NBITS-1:0] PULSE_END = NBITS'(PULSE_CLKS);
   localparam logic [OW-1:0]    PERIOD    = OW'(NCLKS_TOTAL);
   localparam logic [HW-1:0]    HITS_LOCK = HW'(LOCK_COUNT);
   localparam logic [HW-1:0]    HITS_ONE  = HW'(1);
   localparam logic [MW-1:0]    MISS_MAX  = MW'(HOLDOVER_MAX);
   localparam logic [MW-1:0]    MISS_ONE  = MW'(1);

   typedef enum logic [1:0] {
      ST_FREERUN  = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HOLDOVER = 2'd3
   } state_t;

   logic sync_meta, sync_q, sync_prev, sync_edge;

   state_t            state_q, state_d;
   logic [HW-1:0]     hits_q, hits_d;
   logic [MW-1:0]     misses_q, misses_d;
   logic              seen_q, seen_d;
   logic              run_q;
   logic [NBITS-1:0]  counter_d;
   logic signed [NBITS:0] offset_d;
   logic              in_window, miss;

   // Two-flop synchronizer plus registered rising-edge detect (3 clk latency)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         sync_prev <= 1'b0;
         sync_edge <= 1'b0;
      end else begin
         sync_meta <= sync_in;
         sync_q    <= sync_meta;
         sync_prev <= sync_q;
         sync_edge <= sync_q & ~sync_prev;
      end
   end

   // Next-state: counter realign, window classification, lock tracking
   always_comb begin
      state_d   = state_q;
      hits_d    = hits_q;
      misses_d  = misses_q;
      seen_d    = seen_q;
      offset_d  = offset;
      counter_d = '0;
      in_window = (counter_out <= WIN_LO) || (counter_out >= WIN_HI);
      // Miss is judged as the counter steps onto SYNC_WINDOW+1 without an edge
      miss      = run_q && !sync_edge && !seen_q && (counter_out == WIN_LO);

      if (!en) begin
         state_d  = ST_FREERUN;
         hits_d   = '0;
         misses_d = '0;
         seen_d   = 1'b0;
      end else begin
         if (sync_edge || !run_q || (counter_out == CNT_LAST))
            counter_d = '0;
         else
            counter_d = counter_out + NBITS'(1);

         if (sync_edge)
            seen_d = 1'b1;
         else if (counter_out == WIN_HI)
            seen_d = 1'b0;

         if (sync_edge && in_window)
            offset_d = (counter_out <= WIN_LO) ? $signed({1'b0, counter_out})
                                               : $signed({1'b0, counter_out} - PERIOD);

         case (state_q)
            ST_FREERUN: begin
               if (sync_edge) begin
                  hits_d  = HITS_ONE;
                  state_d = ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (sync_edge) begin
                  if (!in_window) begin
                     hits_d = HITS_ONE;
                  end else if (hits_q >= HITS_LOCK - HITS_ONE) begin
                     hits_d   = HITS_LOCK;
                     misses_d = '0;
                     state_d  = ST_LOCKED;
                  end else begin
                     hits_d = hits_q + HITS_ONE;
                  end
               end else if (miss) begin
                  hits_d  = '0;
                  state_d = ST_FREERUN;
               end
            end
            ST_LOCKED: begin
               if (sync_edge) begin
                  if (in_window) begin
                     misses_d = '0;
                  end else begin
                     hits_d  = HITS_ONE;
                     state_d = ST_ACQUIRE;
                  end
               end else if (miss) begin
                  misses_d = MISS_ONE;
                  state_d  = ST_HOLDOVER;
               end
            end
            ST_HOLDOVER: begin
               if (sync_edge) begin
                  misses_d = '0;
                  if (in_window) begin
                     state_d = ST_LOCKED;
                  end else begin
                     hits_d  = HITS_ONE;
                     state_d = ST_ACQUIRE;
                  end
               end else if (miss) begin
                  if (misses_q >= MISS_MAX - MISS_ONE) begin
                     hits_d   = '0;
                     misses_d = '0;
                     state_d  = ST_FREERUN;
                  end else begin
                     misses_d = misses_q + MISS_ONE;
                  end
               end
            end
            default: state_d = ST_FREERUN;
         endcase
      end
   end

   // State register and registered outputs, aligned with counter_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FREERUN;
         hits_q      <= '0;
         misses_q    <= '0;
         seen_q      <= 1'b0;
         run_q       <= 1'b0;
         counter_out <= '0;
         pps_out     <= 1'b0;
         tick        <= 1'b0;
         locked      <= 1'b0;
         holdover    <= 1'b0;
         offset      <= '0;
      end else begin
         state_q     <= state_d;
         hits_q      <= hits_d;
         misses_q    <= misses_d;
         seen_q      <= seen_d;
         run_q       <= en;
         counter_out <= counter_d;
         pps_out     <= en && (counter_d < PULSE_END);
         tick        <= en && (counter_d == '0);
         locked      <= (state_d == ST_LOCKED);
         holdover    <= (state_d == ST_HOLDOVER);
         offset      <= offset_d;
      end
   end

endmodule

// File: doc/pps_disciplined_gen.md
PPS_DISCIPLINED_GEN -- requirements
Module: pps_disciplined_gen

Interface
REQ-001 SHALL have parameter NBITS, default 26, width of counter_out.
REQ-002 SHALL have parameter NCLKS_TOTAL, default 50000000, clk cycles per PPS period.
REQ-003 SHALL have parameter PULSE_CLKS, default 5000000, pps_out high time in clk cycles (1..NCLKS_TOTAL-1).
REQ-004 SHALL have parameter SYNC_WINDOW, default 500, accepted sync edge tolerance in clk cycles (1..NCLKS_TOTAL/4).
REQ-005 SHALL have parameter LOCK_COUNT, default 3, consecutive in-window edges required to lock.
REQ-006 SHALL have parameter HOLDOVER_MAX, default 10, consecutive missed edges tolerated before free-run.
REQ-007 SHALL have port clk  input  1  sole clock.
REQ-008 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-009 SHALL have port en  input  1  generator enable.
REQ-010 SHALL have port sync_in  input  1  external PPS reference, asynchronous to clk.
REQ-011 SHALL have port counter_out  output  NBITS  phase counter, 0..NCLKS_TOTAL-1.
REQ-012 SHALL have port pps_out  output  1  generated PPS pulse.
REQ-013 SHALL have port tick  output  1  one-cycle strobe, counter_out==0.
REQ-014 SHALL have port locked  output  1  state==LOCKED.
REQ-015 SHALL have port holdover  output  1  state==HOLDOVER.
REQ-016 SHALL have port offset  output  NBITS+1  signed: last accepted edge phase error.

Function
REQ-017 sync_in SHALL pass a 2-flop synchronizer plus rising-edge detector; internal sync_edge asserts 3 clk after a sync_in rise, one cycle wide.
REQ-018 counter_out SHALL increment by 1 per clk and wrap NCLKS_TOTAL-1 -> 0; on sync_edge (en=1, state != FREERUN excluded only by REQ-025) next value SHALL be 0.
REQ-019 pps_out SHALL be registered, high exactly when en=1 and counter_out < PULSE_CLKS, same cycle as counter_out.
REQ-020 tick SHALL be high exactly when en=1 and counter_out==0.
REQ-021 In-window: sync_edge while counter_out <= SYNC_WINDOW or counter_out >= NCLKS_TOTAL-SYNC_WINDOW; otherwise out-of-window.
REQ-022 On in-window edge, offset SHALL load c if c <= SYNC_WINDOW, else c-NCLKS_TOTAL (c = counter_out at edge); offset unchanged otherwise.
REQ-023 Miss: counter_out reaches SYNC_WINDOW+1 with no sync_edge since counter_out last equalled NCLKS_TOTAL-SYNC_WINDOW (or since reset/realign); edge on same cycle as miss evaluation takes priority.
REQ-024 FSM states FREERUN, ACQUIRE, LOCKED, HOLDOVER; counters hits (LOCK_COUNT range) and misses (HOLDOVER_MAX range).
REQ-025 FREERUN: any sync_edge -> realign, hits=1, ACQUIRE; misses not counted.
REQ-026 ACQUIRE: in-window edge -> hits+1, -> LOCKED when hits reaches LOCK_COUNT; out-of-window edge -> hits=1, stay; miss -> hits=0, FREERUN.
REQ-027 LOCKED: in-window edge -> stay, misses=0; out-of-window edge -> hits=1, ACQUIRE; miss -> misses=1, HOLDOVER.
REQ-028 HOLDOVER: counter free-runs; in-window edge -> misses=0, LOCKED; out-of-window edge -> hits=1, ACQUIRE; miss -> misses+1, -> FREERUN when misses reaches HOLDOVER_MAX.
REQ-029 en=0 SHALL hold counter_out=0, state FREERUN, hits=misses=0, pps_out=tick=0; offset held; synchronizer keeps running; edges ignored.
REQ-030 en 0->1 SHALL start counting from 0 on the next clk.

Reset
REQ-031 rst_n low SHALL immediately force counter_out=0, pps_out=0, tick=0, locked=0, holdover=0, offset=0, state FREERUN, hits=misses=0, synchronizer flops 0.
REQ-032 Reset mid-pulse or mid-lock SHALL abandon all history; after release behaviour equals power-on.

Verification (NCLKS_TOTAL=100, PULSE_CLKS=10, SYNC_WINDOW=4, LOCK_COUNT=3, HOLDOVER_MAX=2, NBITS=7)
REQ-033 No sync_in, en=1 for 250 clk -> counter wraps 99->0, pps_out high counter 0..9, tick every 100 clk, locked=0.
REQ-034 sync_in rises every 100 clk, first arbitrary -> ACQUIRE after 1st edge, locked=1 after 3rd edge, offset 0.
REQ-035 Locked, then sync period 102 -> each edge in-window, offset=+2, counter realigned, locked stays 1.
REQ-036 Locked, sync_in stopped -> holdover=1 at counter 5 of first missed period, FREERUN after 2nd miss, pps_out continues unbroken.
REQ-037 Locked, one edge at counter 50 -> ACQUIRE, counter 0 next cycle, locked=0, offset unchanged.
REQ-038 rst_n low for 1 cycle while LOCKED and pps_out=1 -> all outputs 0 immediately; en=0 -> counter_out stays 0, edges ignored.
